// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider:
// controller states and iteration sizing.
package div_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int N_ITER    = DEF_WIDTH;
    localparam int CNT_W     = $clog2(N_ITER);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_A = 4'd1,
        LOAD_Q = 4'd2,
        LOAD_M = 4'd3,
        CHECK  = 4'd4,
        ITER   = 4'd5,
        CORR   = 4'd6,
        OUT_R  = 4'd7,
        OUT_Q  = 4'd8,
        DONE   = 4'd9
    } state_t;

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Shared-bus connection of the divider: serial operand input,
// serial result output and completion/error flags.
interface nonrestoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             enable;
    logic [WIDTH-1:0] inbus;
    logic             done;
    logic             div_err;
    logic [WIDTH-1:0] outbus;

    modport master (
        output enable,
        output inbus,
        input  done,
        input  div_err,
        input  outbus
    );

    modport slave (
        input  enable,
        input  inbus,
        output done,
        output div_err,
        output outbus
    );
endinterface

// File: rtl/addsub_nbits.sv
// Combinational two's complement adder/subtractor. Subtraction inverts b
// and injects the carry-in; the carry out of the top bit is dropped.
module addsub_nbits #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_sum
);
    logic [N-1:0] w_b_eff;

    // Conditional inversion of b, then add with sub as carry-in.
    always_comb begin
        w_b_eff = i_b ^ {N{i_sub}};
        o_sum   = i_a + w_b_eff + {{(N-1){1'b0}}, i_sub};
    end
endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned 2W-by-W non-restoring divider on the shared 8-bit bus.
// Operands arrive serially (dividend high, dividend low, divisor); the
// remainder then the quotient are presented on outbus, followed by a
// one-cycle done pulse. div_err flags divide-by-zero or quotient overflow.
//
//   state  | meaning
//   IDLE   | waiting for enable
//   LOAD_A | capture dividend high byte into A
//   LOAD_Q | capture dividend low byte into Q
//   LOAD_M | capture divisor into M
//   CHECK  | reject M==0 or quotient overflow (A_hi >= M)
//   ITER   | one shift + add/sub step per cycle, N_ITER cycles
//   CORR   | restore a negative final remainder
//   OUT_R  | present remainder
//   OUT_Q  | present quotient
//   DONE   | one-cycle completion pulse
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    nonrestoring_divider_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_shift_a;
    logic [WIDTH:0]     w_as_a;
    logic               w_as_sub;
    logic [WIDTH:0]     w_as_sum;
    logic               w_bad_div;
    logic               w_done;
    logic [WIDTH-1:0]   w_outbus;

    assign w_m_ext   = {1'b0, r_m};
    assign w_shift_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_bad_div = (r_m == '0) || (r_a[WIDTH-1:0] >= r_m);

    // Adder operand select: shifted A with sign-driven op while iterating,
    // plain A + M during the final correction.
    always_comb begin
        w_as_a   = w_shift_a;
        w_as_sub = ~r_a[WIDTH];
        if (r_state == CORR) begin
            w_as_a   = r_a;
            w_as_sub = 1'b0;
        end
    end

    addsub_nbits #(
        .N (WIDTH + 1)
    ) u_addsub (
        .i_a   (w_as_a),
        .i_b   (w_m_ext),
        .i_sub (w_as_sub),
        .o_sum (w_as_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; outbus is zero except in OUT_R/OUT_Q.
    always_comb begin
        w_next   = r_state;
        w_done   = 1'b0;
        w_outbus = '0;
        case (r_state)
            IDLE:    if (bus.enable) w_next = LOAD_A;
            LOAD_A:  w_next = LOAD_Q;
            LOAD_Q:  w_next = LOAD_M;
            LOAD_M:  w_next = CHECK;
            CHECK:   w_next = w_bad_div ? DONE : ITER;
            ITER:    if (r_cnt == CNT_LAST) w_next = CORR;
            CORR:    w_next = OUT_R;
            OUT_R: begin
                w_outbus = r_a[WIDTH-1:0];
                w_next   = OUT_Q;
            end
            OUT_Q: begin
                w_outbus = r_q;
                w_next   = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration steps, correction, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE:   if (bus.enable) r_err <= 1'b0;
                LOAD_A: r_a <= {1'b0, bus.inbus};
                LOAD_Q: r_q <= bus.inbus;
                LOAD_M: r_m <= bus.inbus;
                CHECK: begin
                    if (w_bad_div) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ITER: begin
                    r_a   <= w_as_sum;
                    r_q   <= {r_q[WIDTH-2:0], ~w_as_sum[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                end
                CORR:   if (r_a[WIDTH]) r_a <= w_as_sum;
                default: ;
            endcase
        end
    end

    assign bus.done    = w_done;
    assign bus.div_err = r_err;
    assign bus.outbus  = w_outbus;
endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for the non-restoring divider: the driver pushes the
// arithmetic expectation of each operation; a monitor checks results,
// error flag and latency whenever done pulses.
module tb_nonrestoring_divider;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [7:0] rem;
        logic [7:0] quot;
        logic       err;
        int         start;
    } exp_t;

    exp_t sb[$];

    nonrestoring_divider_if #(.WIDTH(8)) bus ();

    nonrestoring_divider #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] hi, input logic [7:0] lo,
                                   input logic [7:0] m, input int start);
        exp_t e;
        int   dividend;
        dividend = {16'd0, hi, lo};
        e.start  = start;
        e.rem    = 8'd0;
        e.quot   = 8'd0;
        e.err    = 1'b0;
        if (m == 8'd0 || (dividend / int'(m)) > 255) begin
            e.err = 1'b1;
        end else begin
            e.quot = 8'(dividend / int'(m));
            e.rem  = 8'(dividend % int'(m));
        end
        return e;
    endfunction

    // Monitor: outbus history gives the two result bytes preceding done.
    logic [7:0] h1, h2;
    initial begin
        h1 = 8'd0;
        h2 = 8'd0;
    end
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no operation pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.start, e.err ? 5 : 16);
                    check("div_err", int'(bus.div_err), int'(e.err));
                    check("outbus_at_done", int'(bus.outbus), 0);
                    if (e.err) begin
                        check("err_outbus_prev2", int'(h2), 0);
                        check("err_outbus_prev1", int'(h1), 0);
                    end else begin
                        check("remainder", int'(h2), int'(e.rem));
                        check("quotient", int'(h1), int'(e.quot));
                    end
                end
            end else if (sb.size() == 0 && bus.outbus != 8'd0) begin
                checks++;
                failures++;
                $display("FAIL stray_outbus: got 0x%0h expected 0x0 (cycle %0d)", bus.outbus, cyc);
            end
        end
        h2 = h1;
        h1 = bus.outbus;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call at cycle 0 (#1 after an edge with the DUT in IDLE); returns in cycle 4.
    task automatic start_op(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] m, input bit keep_en, input bit push);
        bus.enable = 1'b1;
        if (push) sb.push_back(model(hi, lo, m, cyc));
        wait_cycles(1);
        bus.enable = keep_en;
        bus.inbus  = hi;
        wait_cycles(1);
        bus.inbus  = lo;
        wait_cycles(1);
        bus.inbus  = m;
        wait_cycles(1);
        bus.inbus  = 8'($urandom());
    endtask

    task automatic run_op(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] m);
        exp_t e;
        e = model(hi, lo, m, 0);
        start_op(hi, lo, m, 1'b0, 1'b1);
        wait_cycles(e.err ? 3 : 14);
    endtask

    initial begin
        logic [7:0] hi, lo, m;
        int         guard;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.inbus  = 8'd0;
        wait_cycles(3);
        check("reset_done", int'(bus.done), 0);
        check("reset_div_err", int'(bus.div_err), 0);
        check("reset_outbus", int'(bus.outbus), 0);
        rst = 1'b0;
        wait_cycles(2);

        run_op(8'h03, 8'hE8, 8'h07);
        run_op(8'hFE, 8'h01, 8'hFF);

        start_op(8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
        wait_cycles(3);
        check("div_err_held_zero_div", int'(bus.div_err), 1);

        start_op(8'h05, 8'h00, 8'h05, 1'b0, 1'b1);
        wait_cycles(3);
        check("div_err_held_overflow", int'(bus.div_err), 1);
        run_op(8'h00, 8'h00, 8'h05);
        check("div_err_cleared", int'(bus.div_err), 0);

        // Abort mid-iteration; ignored enable at cycle 7, reset at cycle 8.
        start_op(8'h00, 8'h64, 8'h0A, 1'b0, 1'b0);
        wait_cycles(3);
        bus.enable = 1'b1;
        wait_cycles(1);
        bus.enable = 1'b0;
        rst        = 1'b1;
        wait_cycles(1);
        check("abort_done", int'(bus.done), 0);
        check("abort_outbus", int'(bus.outbus), 0);
        rst = 1'b0;
        wait_cycles(1);
        run_op(8'h00, 8'h64, 8'h0A);

        // Back-to-back: enable held through DONE restarts in the next IDLE.
        start_op(8'h00, 8'h64, 8'h0A, 1'b1, 1'b1);
        wait_cycles(13);
        start_op(8'h00, 8'hFF, 8'h10, 1'b0, 1'b1);
        wait_cycles(14);

        for (int i = 0; i < 40; i++) begin
            lo = 8'($urandom());
            if (($urandom() % 4) != 0) begin
                m  = 8'($urandom_range(255, 1));
                hi = 8'($urandom_range(int'(m) - 1, 0));
            end else begin
                m  = (($urandom() % 3) == 0) ? 8'd0 : 8'($urandom());
                hi = 8'($urandom());
            end
            run_op(hi, lo, m);
            wait_cycles(int'($urandom_range(2, 0)));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            wait_cycles(1);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
        end
        wait_cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
